// File: rtl/seq_divider_pkg.sv
// Shared constants for the sequential divider: default operand width and
// the controller state encoding.
package seq_divider_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/seq_divider_rca.sv
// Plain n-bit ripple-carry adder; the divider uses it as A + ~B + 1 for its
// trial subtraction.
module N_Bit_RCA #(
  parameter int n = 4
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         cin,
  output logic [n-1:0] sum,
  output logic         carry_out
);

  logic [n:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < n; i++) begin : g_bit
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1]   = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign carry_out = carry[n];

endmodule

// File: rtl/seq_divider.sv
// Fixed-latency restoring divider, signed or unsigned, one quotient bit per
// cycle, with divide-by-zero and signed-overflow results defined explicitly.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int n = DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         is_signed,
  input  logic [n-1:0] dividend,
  input  logic [n-1:0] divisor,
  output logic [n-1:0] quotient,
  output logic [n-1:0] remainder,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(n) + 1;

  state_t        state;
  logic [CW-1:0] count;
  logic          sgn_mode;
  logic          q_neg;
  logic          r_neg;
  logic [n-1:0]  dividend_raw;
  logic [n-1:0]  divisor_raw;
  logic [n-1:0]  divisor_mag;
  logic [n-1:0]  quot_sr;
  logic [n-1:0]  part_rem;
  logic [n:0]    shifted;
  logic [n:0]    diff;
  logic          no_borrow;
  logic          accept;
  logic [n-1:0]  dividend_mag;
  logic [n-1:0]  divisor_abs;
  logic [n-1:0]  fix_q;
  logic [n-1:0]  fix_r;

  // quot_sr starts as the dividend magnitude and is shifted out MSB first
  // while quotient bits are shifted in at the bottom.
  assign shifted = {part_rem, quot_sr[n-1]};

  N_Bit_RCA #(.n(n + 1)) u_trial_sub (
    .a         (shifted),
    .b         (~{1'b0, divisor_mag}),
    .cin       (1'b1),
    .sum       (diff),
    .carry_out (no_borrow)
  );

  // diff[n] is always 0 on a genuine no-borrow; folding it in keeps the
  // accepted remainder provably within n bits.
  assign accept = no_borrow & ~diff[n];

  assign dividend_mag = (is_signed && dividend[n-1]) ? -dividend : dividend;
  assign divisor_abs  = (is_signed && divisor[n-1])  ? -divisor  : divisor;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    fix_q = quot_sr;
    fix_r = part_rem;
    if (divisor_raw == '0) begin
      fix_q = '1;
      fix_r = dividend_raw;
    end else if (sgn_mode && dividend_raw == {1'b1, {(n-1){1'b0}}} &&
                 divisor_raw == '1) begin
      fix_q = dividend_raw;
      fix_r = '0;
    end else begin
      if (q_neg) fix_q = -quot_sr;
      if (r_neg) fix_r = -part_rem;
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values and the update order within the block is moot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      count        <= '0;
      sgn_mode     <= 1'b0;
      q_neg        <= 1'b0;
      r_neg        <= 1'b0;
      dividend_raw <= '0;
      divisor_raw  <= '0;
      divisor_mag  <= '0;
      quot_sr      <= '0;
      part_rem     <= '0;
      quotient     <= '0;
      remainder    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sgn_mode     <= is_signed;
            q_neg        <= is_signed & (dividend[n-1] ^ divisor[n-1]);
            r_neg        <= is_signed & dividend[n-1];
            dividend_raw <= dividend;
            divisor_raw  <= divisor;
            divisor_mag  <= divisor_abs;
            quot_sr      <= dividend_mag;
            part_rem     <= '0;
            count        <= '0;
            busy         <= 1'b1;
            state        <= RUN;
          end
        end
        RUN: begin
          part_rem <= accept ? diff[n-1:0] : shifted[n-1:0];
          quot_sr  <= {quot_sr[n-2:0], accept};
          count    <= count + 1'b1;
          if (count == CW'(n - 1)) state <= FIX;
        end
        FIX: begin
          quotient  <= fix_q;
          remainder <= fix_r;
          done      <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (n=32): directed vector table, multi-cycle
// corner sequences, and randomized operations against an arithmetic model.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  localparam int LAT = 34;

  seq_divider #(.n(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_q;
    logic [31:0] exp_r;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic with the two defined special cases.
  function automatic void ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = a;
        r = 32'd0;
      end else begin
        q = 32'($signed(a) / $signed(b));
        r = 32'($signed(a) % $signed(b));
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Starts one operation from IDLE; returns at the negedge of the done cycle
  // (lat = cycle index after the start edge, -1 on timeout).
  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] q, output logic [31:0] r,
                        output int lat, output logic busy_ok);
    @(negedge clk);
    start = 1'b1; is_signed = sgn; dividend = a; divisor = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    busy_ok = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    q = quotient;
    r = remainder;
  endtask

  vec_t        vecs[$];
  logic [31:0] q, r, eq, er, a, b;
  logic        sgn, bok;
  int          lat, ndone, first_done;

  initial begin
    rst = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;

    vecs.push_back('{1'b0, 32'd100,       32'd7,         32'd14,        32'd2});
    vecs.push_back('{1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF});
    vecs.push_back('{1'b0, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5});
    vecs.push_back('{1'b1, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5});
    vecs.push_back('{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0});
    vecs.push_back('{1'b0, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0});
    vecs.push_back('{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         32'd0});
    vecs.push_back('{1'b0, 32'd3,         32'd10,        32'd0,         32'd3});
    vecs.push_back('{1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1});
    vecs.push_back('{1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF});
    vecs.push_back('{1'b1, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFF9});
    vecs.push_back('{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000});

    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_quotient", quotient, 32'd0);
    check("reset_remainder", remainder, 32'd0);
    rst = 1'b0;

    // Idle with start low holds the reset outputs.
    repeat (3) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_quotient", quotient, 32'd0);

    foreach (vecs[i]) begin
      run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, q, r, lat, bok);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT));
      check($sformatf("vec%0d_busy", i), 32'(bok), 32'd1);
      check($sformatf("vec%0d_quotient", i), q, vecs[i].exp_q);
      check($sformatf("vec%0d_remainder", i), r, vecs[i].exp_r);
      @(negedge clk);
      check($sformatf("vec%0d_done_single", i), 32'(done), 32'd0);
      check($sformatf("vec%0d_idle", i), 32'(busy), 32'd0);
    end

    // start pulsed with other operands mid-RUN is ignored.
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk);
    @(negedge clk);
    ndone = 0; first_done = -1; q = '0; r = '0;
    for (int k = 1; k <= 80; k++) begin
      if (k == 5) begin
        start = 1'b1; dividend = 32'd9; divisor = 32'd3;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        ndone++;
        if (first_done < 0) begin
          first_done = k; q = quotient; r = remainder;
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_start_latency", 32'(first_done), 32'(LAT));
    check("busy_start_done_count", 32'(ndone), 32'd1);
    check("busy_start_quotient", q, 32'd14);
    check("busy_start_remainder", r, 32'd2);

    // start during the DONE cycle is ignored; results hold afterwards.
    run_op(1'b0, 32'd20, 32'd4, q, r, lat, bok);
    check("done_start_q", q, 32'd5);
    start = 1'b1; dividend = 32'd77; divisor = 32'd5;
    @(negedge clk);
    start = 1'b0;
    check("done_start_busy", 32'(busy), 32'd0);
    ndone = 0;
    for (int k = 0; k < 50; k++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("done_start_no_done", 32'(ndone), 32'd0);
    check("hold_quotient", quotient, 32'd5);
    check("hold_remainder", remainder, 32'd0);

    // Reset mid-RUN: next cycle idle, outputs cleared, no done pulse.
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int k = 1; k <= 10; k++) begin
      if (done) ndone++;
      if (k == 10) rst = 1'b1;
      @(negedge clk);
    end
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_quotient", quotient, 32'd0);
    check("rst_mid_remainder", remainder, 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("rst_mid_no_done", 32'(ndone), 32'd0);
    run_op(1'b0, 32'd9, 32'd3, q, r, lat, bok);
    check("after_rst_latency", 32'(lat), 32'(LAT));
    check("after_rst_quotient", q, 32'd3);
    check("after_rst_remainder", r, 32'd0);

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 200; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'hFFFF_FFFF;
        3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        4: begin a = 32'($urandom_range(0, 1000)); b = $urandom; end
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      ref_div(sgn, a, b, eq, er);
      run_op(sgn, a, b, q, r, lat, bok);
      check($sformatf("rand%0d_latency", i), 32'(lat), 32'(LAT));
      check($sformatf("rand%0d_quotient s=%0b a=%h b=%h", i, sgn, a, b), q, eq);
      check($sformatf("rand%0d_remainder s=%0b a=%h b=%h", i, sgn, a, b), r, er);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have parameter n, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-005 The block SHALL have port is_signed, input, 1 bit: 1 means two's-complement operands, 0 means unsigned; sampled with start.
REQ-006 The block SHALL have port dividend, input, n bits: numerator; sampled with start.
REQ-007 The block SHALL have port divisor, input, n bits: denominator; sampled with start.
REQ-008 The block SHALL have port quotient, output, n bits: result quotient, registered.
REQ-009 The block SHALL have port remainder, output, n bits: result remainder, registered.
REQ-010 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 The block SHALL have port done, output, 1 bit: single-cycle pulse when quotient and remainder are valid.

Function
REQ-012 The FSM SHALL have exactly four states, IDLE, RUN, FIX and DONE, and SHALL be in IDLE after reset.
REQ-013 In IDLE with start=1, the block SHALL latch the operands and is_signed, clear the partial remainder and the iteration counter, and enter RUN on the next edge.
REQ-014 In IDLE with start=0, the block SHALL stay in IDLE and hold quotient and remainder unchanged.
REQ-015 Signed operands SHALL be converted to magnitudes at latch time, and the quotient sign (dividend sign XOR divisor sign) and remainder sign (dividend sign) SHALL be stored.
REQ-016 RUN SHALL perform one restoring step per cycle for exactly n cycles, MSB first:
- shift the partial remainder left, bringing in the next dividend bit;
- trial-subtract the divisor magnitude;
- on no borrow, keep the difference and set the quotient bit to 1; otherwise restore and set the quotient bit to 0.
REQ-017 After the n-th RUN cycle, the block SHALL enter FIX, which applies sign correction (two's-complement negate when the stored sign is 1 and is_signed=1) and writes quotient and remainder.
REQ-018 After FIX, the block SHALL enter DONE for exactly one cycle with done=1, then return to IDLE.
REQ-019 Latency SHALL be fixed: done is high in the (n+2)-th cycle after the start-sampling edge, for all operand values, including the special cases below.
REQ-020 On a divisor of 0, the outputs SHALL be quotient = all ones and remainder = latched dividend (unmodified), regardless of is_signed.
REQ-021 On signed overflow (dividend = 2^(n-1) pattern, divisor = all ones, is_signed=1), the outputs SHALL be quotient = dividend and remainder = 0.
REQ-022 start asserted while busy=1 SHALL be ignored and SHALL NOT corrupt the operation in progress.
REQ-023 start asserted in the DONE cycle SHALL be ignored; a new operation is accepted only in IDLE.
REQ-024 quotient and remainder SHALL hold their last written values from DONE until the next FIX state.
REQ-025 The trial subtraction SHALL be (n+1) bits wide, so that the shifted partial remainder does not overflow.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE, quotient=0, remainder=0, busy=0, done=0, and clear the counter and internal registers.
REQ-027 Reset SHALL take priority over start and over any state, including mid-RUN.
REQ-028 A reset during an operation SHALL NOT produce a done pulse.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding constants and the default width constant (32).
REQ-030 The trial subtraction SHALL be implemented by one instance of the existing N_Bit_RCA at width n+1, computing A + ~B with Cin=1; its carry_out=1 means no borrow.

Verification
REQ-031 With n=32, unsigned 100 / 7 SHALL give done in cycle 34, quotient=14, remainder=2.
REQ-032 Signed 0xFFFFFFF9 (-7) / 2 SHALL give quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1).
REQ-033 Divide by zero, 5 / 0, signed and unsigned, SHALL give quotient=0xFFFFFFFF, remainder=5, with done in cycle 34.
REQ-034 Signed 0x80000000 / 0xFFFFFFFF SHALL give quotient=0x80000000, remainder=0.
REQ-035 Starting 100/7, then pulsing start with 9/3 at cycle 5, SHALL still give quotient=14 and remainder=2, with no second done.
REQ-036 Starting 100/7, then asserting rst at cycle 10, SHALL return to IDLE next cycle with busy=0, no done, and outputs 0; a following 9/3 SHALL give quotient=3, remainder=0.
